// File: rtl/pipe_pkg.sv
// Shared pipeline constants: datapath widths, forward-select encodings and ALU function codes.
package pipe_pkg;

    localparam int unsigned DW     = 32;
    localparam int unsigned RW     = 5;
    localparam int unsigned CTRL_W = 4;

    localparam logic [1:0] FWD_REG   = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    typedef enum logic [CTRL_W-1:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_NAND, ALU_SLT, ALU_SLTU,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_ROL, ALU_ROR, ALU_LUI, ALU_PASSB, ALU_XOR
    } alu_op_e;

endpackage

// File: rtl/fwd_select.sv
// Per-operand forwarding: compares a source specifier against EX/MEM and MEM/WB destinations
// and muxes the youngest matching producer over the stored register value.
module fwd_select
    import pipe_pkg::*;
#(
    parameter int unsigned DW = pipe_pkg::DW,
    parameter int unsigned RW = pipe_pkg::RW
) (
    input  logic [RW-1:0] rs,
    input  logic [0:DW-1] reg_val,
    input  logic [RW-1:0] exmem_rd,
    input  logic          exmem_reg_write,
    input  logic [0:DW-1] exmem_result,
    input  logic [RW-1:0] memwb_rd,
    input  logic          memwb_reg_write,
    input  logic [0:DW-1] memwb_result,
    output logic [1:0]    sel,
    output logic [0:DW-1] value
);

    logic rs_nonzero;

    assign rs_nonzero = (rs != '0);

    // EX/MEM is checked first: it holds the younger producer of the register.
    always_comb begin
        sel   = FWD_REG;
        value = reg_val;
        if (rs_nonzero && exmem_reg_write && (exmem_rd == rs)) begin
            sel   = FWD_EXMEM;
            value = exmem_result;
        end else if (rs_nonzero && memwb_reg_write && (memwb_rd == rs)) begin
            sel   = FWD_MEMWB;
            value = memwb_result;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding feeding the ALU.
// Stall holds control but refreshes stored operands; flush inserts a bubble and wins over stall.
module id_ex_operand_stage
    import pipe_pkg::*;
#(
    parameter int unsigned DW = pipe_pkg::DW,
    parameter int unsigned RW = pipe_pkg::RW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [RW-1:0]     id_rs1,
    input  logic [RW-1:0]     id_rs2,
    input  logic [RW-1:0]     id_rd,
    input  logic              id_reg_write,
    input  logic [0:DW-1]     id_busA,
    input  logic [0:DW-1]     id_busB,
    input  logic [0:DW-1]     id_imm,
    input  logic              id_use_imm,
    input  logic [CTRL_W-1:0] id_alu_ctrl,
    input  logic [RW-1:0]     exmem_rd,
    input  logic              exmem_reg_write,
    input  logic [0:DW-1]     exmem_result,
    input  logic [RW-1:0]     memwb_rd,
    input  logic              memwb_reg_write,
    input  logic [0:DW-1]     memwb_result,
    output logic [0:DW-1]     alu_a,
    output logic [0:DW-1]     alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic [0:DW-1]     ex_store_data,
    output logic [RW-1:0]     ex_rd,
    output logic              ex_reg_write,
    output logic              ex_valid,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);

    logic              valid_q, valid_d;
    logic              reg_write_q, reg_write_d;
    logic [RW-1:0]     rd_q, rd_d;
    logic [RW-1:0]     rs1_q, rs1_d;
    logic [RW-1:0]     rs2_q, rs2_d;
    logic [0:DW-1]     bus_a_q, bus_a_d;
    logic [0:DW-1]     bus_b_q, bus_b_d;
    logic [0:DW-1]     imm_q, imm_d;
    logic              use_imm_q, use_imm_d;
    logic [CTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;

    logic [0:DW-1]     rs1_val;
    logic [0:DW-1]     rs2_val;

    fwd_select #(.DW(DW), .RW(RW)) u_fwd_a (
        .rs              (rs1_q),
        .reg_val         (bus_a_q),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_result    (memwb_result),
        .sel             (fwd_a),
        .value           (rs1_val)
    );

    fwd_select #(.DW(DW), .RW(RW)) u_fwd_b (
        .rs              (rs2_q),
        .reg_val         (bus_b_q),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_result    (memwb_result),
        .sel             (fwd_b),
        .value           (rs2_val)
    );

    always_comb begin
        valid_d     = valid_q;
        reg_write_d = reg_write_q;
        rd_d        = rd_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        bus_a_d     = bus_a_q;
        bus_b_d     = bus_b_q;
        imm_d       = imm_q;
        use_imm_d   = use_imm_q;
        alu_ctrl_d  = alu_ctrl_q;
        if (flush) begin
            // Bubble: rs=0 guarantees the slot never forwards.
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            rd_d        = '0;
            rs1_d       = '0;
            rs2_d       = '0;
            bus_a_d     = '0;
            bus_b_d     = '0;
            imm_d       = '0;
            use_imm_d   = 1'b0;
            alu_ctrl_d  = '0;
        end else if (stall) begin
            // Latch forwarded values so a producer retiring during the stall is not lost.
            bus_a_d = rs1_val;
            bus_b_d = rs2_val;
        end else begin
            valid_d     = id_valid;
            reg_write_d = id_reg_write & id_valid;
            rd_d        = id_rd;
            rs1_d       = id_rs1;
            rs2_d       = id_rs2;
            bus_a_d     = id_busA;
            bus_b_d     = id_busB;
            imm_d       = id_imm;
            use_imm_d   = id_use_imm;
            alu_ctrl_d  = id_alu_ctrl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            bus_a_q     <= '0;
            bus_b_q     <= '0;
            imm_q       <= '0;
            use_imm_q   <= 1'b0;
            alu_ctrl_q  <= '0;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            bus_a_q     <= bus_a_d;
            bus_b_q     <= bus_b_d;
            imm_q       <= imm_d;
            use_imm_q   <= use_imm_d;
            alu_ctrl_q  <= alu_ctrl_d;
        end
    end

    assign alu_a         = rs1_val;
    assign ex_store_data = rs2_val;
    assign alu_b         = use_imm_q ? imm_q : rs2_val;
    assign alu_ctrl      = alu_ctrl_q;
    assign ex_rd         = rd_q;
    assign ex_reg_write  = reg_write_q;
    assign ex_valid      = valid_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: scenario tasks with a scoreboard queue of
// expected EX-stage outputs pushed at issue and popped once the instruction reaches EX.
module tb_id_ex_operand_stage;
    import pipe_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        stall, flush;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_reg_write;
    logic [0:31] id_busA, id_busB, id_imm;
    logic        id_use_imm;
    logic [3:0]  id_alu_ctrl;
    logic [4:0]  exmem_rd;
    logic        exmem_reg_write;
    logic [0:31] exmem_result;
    logic [4:0]  memwb_rd;
    logic        memwb_reg_write;
    logic [0:31] memwb_result;
    logic [0:31] alu_a, alu_b, ex_store_data;
    logic [3:0]  alu_ctrl;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_valid;
    logic [1:0]  fwd_a, fwd_b;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] st;
        logic [3:0]  ctrl;
        logic        v;
        logic        rw;
        logic [4:0]  rd;
        logic [1:0]  fa;
        logic [1:0]  fb;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    id_ex_operand_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .flush           (flush),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rd           (id_rd),
        .id_reg_write    (id_reg_write),
        .id_busA         (id_busA),
        .id_busB         (id_busB),
        .id_imm          (id_imm),
        .id_use_imm      (id_use_imm),
        .id_alu_ctrl     (id_alu_ctrl),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_result    (memwb_result),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_ctrl        (alu_ctrl),
        .ex_store_data   (ex_store_data),
        .ex_rd           (ex_rd),
        .ex_reg_write    (ex_reg_write),
        .ex_valid        (ex_valid),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic rw, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] imm, input logic ui,
                            input logic [3:0] ctrl);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_reg_write = rw;
        id_busA = a; id_busB = b; id_imm = imm; id_use_imm = ui; id_alu_ctrl = ctrl;
    endtask

    task automatic set_fwd(input logic [4:0] erd, input logic ew, input logic [31:0] eres,
                           input logic [4:0] mrd, input logic mw, input logic [31:0] mres);
        exmem_rd = erd; exmem_reg_write = ew; exmem_result = eres;
        memwb_rd = mrd; memwb_reg_write = mw; memwb_result = mres;
    endtask

    task automatic test_reset();
        // Forwarding inputs aimed at r0 must not leak through while rs=0.
        set_fwd(5'd0, 1'b1, 32'hFFFF_FFFF, 5'd0, 1'b1, 32'hEEEE_EEEE);
        #1;
        n_cmp++; if (ex_valid !== 1'b0) begin n_err++;
            $display("FAIL reset_valid: got %b want 0", ex_valid); end
        n_cmp++; if (ex_reg_write !== 1'b0) begin n_err++;
            $display("FAIL reset_rw: got %b want 0", ex_reg_write); end
        n_cmp++; if (alu_ctrl !== 4'd0) begin n_err++;
            $display("FAIL reset_ctrl: got %h want 0", alu_ctrl); end
        n_cmp++; if (ex_rd !== 5'd0) begin n_err++;
            $display("FAIL reset_rd: got %h want 0", ex_rd); end
        n_cmp++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || ex_store_data !== 32'd0) begin
            n_err++;
            $display("FAIL reset_data: got a=%h b=%h st=%h want 0", alu_a, alu_b, ex_store_data);
        end
        set_fwd(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);
    endtask

    task automatic test_plain_capture();
        exp_t e;
        @(negedge clk);
        drive_id(1'b1, 5'd1, 5'd2, 5'd6, 1'b1, 32'h5, 32'h7, 32'h0, 1'b0, ALU_ADD);
        exp_q.push_back('{a: 32'h5, b: 32'h7, st: 32'h7, ctrl: ALU_ADD, v: 1'b1, rw: 1'b1,
                          rd: 5'd6, fa: FWD_REG, fb: FWD_REG});
        @(posedge clk); #2;
        e = exp_q.pop_front();
        n_cmp++; if (alu_a !== e.a || alu_b !== e.b) begin n_err++;
            $display("FAIL plain_ops: got a=%h b=%h want a=%h b=%h", alu_a, alu_b, e.a, e.b); end
        n_cmp++; if (fwd_a !== e.fa || fwd_b !== e.fb) begin n_err++;
            $display("FAIL plain_fwd: got %0d/%0d want %0d/%0d", fwd_a, fwd_b, e.fa, e.fb); end
        n_cmp++; if (ex_valid !== e.v || ex_reg_write !== e.rw || ex_rd !== e.rd) begin n_err++;
            $display("FAIL plain_ctl: got v=%b rw=%b rd=%0d want v=%b rw=%b rd=%0d",
                     ex_valid, ex_reg_write, ex_rd, e.v, e.rw, e.rd); end
    endtask

    task automatic test_double_forward();
        exp_t e;
        @(negedge clk);
        drive_id(1'b1, 5'd3, 5'd3, 5'd8, 1'b1, 32'h11, 32'h22, 32'h0, 1'b0, ALU_SUB);
        exp_q.push_back('{a: 32'hAAAA_0000, b: 32'hAAAA_0000, st: 32'hAAAA_0000,
                          ctrl: ALU_SUB, v: 1'b1, rw: 1'b1, rd: 5'd8,
                          fa: FWD_EXMEM, fb: FWD_EXMEM});
        @(posedge clk); #1;
        set_fwd(5'd3, 1'b1, 32'hAAAA_0000, 5'd3, 1'b1, 32'h0000_5555);
        #1;
        e = exp_q.pop_front();
        n_cmp++; if (alu_a !== e.a || alu_b !== e.b || alu_ctrl !== e.ctrl) begin n_err++;
            $display("FAIL dbl_ops: got a=%h b=%h ctrl=%h want a=%h b=%h ctrl=%h",
                     alu_a, alu_b, alu_ctrl, e.a, e.b, e.ctrl); end
        n_cmp++; if (fwd_a !== e.fa || fwd_b !== e.fb) begin n_err++;
            $display("FAIL dbl_fwd: got %0d/%0d want %0d/%0d", fwd_a, fwd_b, e.fa, e.fb); end
        // Drop the EX/MEM producer: same slot now sees only MEM/WB.
        exmem_reg_write = 1'b0;
        #1;
        n_cmp++; if (alu_a !== 32'h5555 || fwd_a !== FWD_MEMWB || fwd_b !== FWD_MEMWB) begin
            n_err++;
            $display("FAIL memwb_fwd: got a=%h fa=%0d fb=%0d want a=00005555 fa=2 fb=2",
                     alu_a, fwd_a, fwd_b); end
        @(negedge clk);
        drive_id(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 32'h33, 32'h44, 32'h0, 1'b0, ALU_AND);
        exp_q.push_back('{a: 32'h33, b: 32'h44, st: 32'h44, ctrl: ALU_AND, v: 1'b1, rw: 1'b1,
                          rd: 5'd9, fa: FWD_REG, fb: FWD_REG});
        @(posedge clk); #1;
        set_fwd(5'd0, 1'b1, 32'hAAAA_0000, 5'd0, 1'b1, 32'h0000_5555);
        #1;
        e = exp_q.pop_front();
        n_cmp++; if (alu_a !== e.a || alu_b !== e.b || fwd_a !== e.fa || fwd_b !== e.fb) begin
            n_err++;
            $display("FAIL r0_nofwd: got a=%h b=%h fa=%0d fb=%0d want a=%h b=%h fa=0 fb=0",
                     alu_a, alu_b, fwd_a, fwd_b, e.a, e.b); end
        set_fwd(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);
    endtask

    task automatic test_immediate();
        exp_t e;
        @(negedge clk);
        drive_id(1'b1, 5'd8, 5'd9, 5'd10, 1'b1, 32'h10, 32'h99, 32'hFFFF_FFFC, 1'b1, ALU_OR);
        exp_q.push_back('{a: 32'h10, b: 32'hFFFF_FFFC, st: 32'h1234, ctrl: ALU_OR, v: 1'b1,
                          rw: 1'b1, rd: 5'd10, fa: FWD_REG, fb: FWD_EXMEM});
        @(posedge clk); #1;
        set_fwd(5'd9, 1'b1, 32'h1234, 5'd0, 1'b0, 32'd0);
        #1;
        e = exp_q.pop_front();
        n_cmp++; if (alu_b !== e.b) begin n_err++;
            $display("FAIL imm_b: got %h want %h", alu_b, e.b); end
        n_cmp++; if (ex_store_data !== e.st || fwd_b !== e.fb || alu_a !== e.a) begin n_err++;
            $display("FAIL imm_store: got st=%h fb=%0d a=%h want st=%h fb=%0d a=%h",
                     ex_store_data, fwd_b, alu_a, e.st, e.fb, e.a); end
        set_fwd(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);
    endtask

    task automatic test_stall_refresh();
        @(negedge clk);
        drive_id(1'b1, 5'd4, 5'd0, 5'd7, 1'b1, 32'h0BAD, 32'h0, 32'h0, 1'b0, ALU_XOR);
        @(posedge clk); #1;
        set_fwd(5'd0, 1'b0, 32'd0, 5'd4, 1'b1, 32'hDEAD_BEEF);
        #1;
        n_cmp++; if (alu_a !== 32'hDEAD_BEEF || fwd_a !== FWD_MEMWB) begin n_err++;
            $display("FAIL pre_stall: got a=%h fa=%0d want a=deadbeef fa=2", alu_a, fwd_a); end
        @(negedge clk);
        stall = 1'b1;
        drive_id(1'b1, 5'd1, 5'd1, 5'd2, 1'b0, 32'h1, 32'h1, 32'h0, 1'b1, ALU_OR);
        @(posedge clk); #1;
        memwb_reg_write = 1'b0;
        stall = 1'b0;
        #1;
        n_cmp++; if (alu_a !== 32'hDEAD_BEEF || fwd_a !== FWD_REG) begin n_err++;
            $display("FAIL stall_refresh: got a=%h fa=%0d want a=deadbeef fa=0", alu_a, fwd_a); end
        n_cmp++; if (alu_ctrl !== ALU_XOR || ex_rd !== 5'd7 || ex_valid !== 1'b1 ||
                     ex_reg_write !== 1'b1) begin n_err++;
            $display("FAIL stall_hold: got ctrl=%h rd=%0d v=%b rw=%b want ctrl=f rd=7 v=1 rw=1",
                     alu_ctrl, ex_rd, ex_valid, ex_reg_write); end
        set_fwd(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);
    endtask

    task automatic test_flush_stall();
        @(negedge clk);
        drive_id(1'b1, 5'd5, 5'd5, 5'd11, 1'b1, 32'h77, 32'h88, 32'h0, 1'b0, ALU_SLT);
        @(posedge clk);
        @(negedge clk);
        stall = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        stall = 1'b0;
        flush = 1'b0;
        set_fwd(5'd5, 1'b1, 32'hCAFE_F00D, 5'd5, 1'b1, 32'hBEEF_0000);
        #1;
        n_cmp++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin n_err++;
            $display("FAIL flush_vld: got v=%b rw=%b want 0 0", ex_valid, ex_reg_write); end
        n_cmp++; if (alu_ctrl !== 4'd0 || ex_rd !== 5'd0) begin n_err++;
            $display("FAIL flush_ctl: got ctrl=%h rd=%0d want 0 0", alu_ctrl, ex_rd); end
        n_cmp++; if (fwd_a !== FWD_REG || fwd_b !== FWD_REG) begin n_err++;
            $display("FAIL flush_nofwd: got %0d/%0d want 0/0", fwd_a, fwd_b); end
        set_fwd(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);
    endtask

    task automatic test_valid_gating();
        @(negedge clk);
        drive_id(1'b0, 5'd1, 5'd2, 5'd12, 1'b1, 32'h1, 32'h2, 32'h0, 1'b0, ALU_ADD);
        @(posedge clk); #2;
        n_cmp++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_rd !== 5'd12) begin
            n_err++;
            $display("FAIL valid_gate: got v=%b rw=%b rd=%0d want v=0 rw=0 rd=12",
                     ex_valid, ex_reg_write, ex_rd); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 24; i++) begin
            logic [4:0]  rs1, rs2, rd, erd, mrd;
            logic [31:0] ba, bb, imm, eres, mres, va, vb;
            logic        v, rw, ui, ew, mw;
            logic [3:0]  ctrl;
            logic [1:0]  fa, fb;
            rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
            rd = 5'($urandom_range(0, 31)); erd = 5'($urandom_range(0, 3));
            mrd = 5'($urandom_range(0, 3));
            ba = $urandom; bb = $urandom; imm = $urandom; eres = $urandom; mres = $urandom;
            v = 1'($urandom); rw = 1'($urandom); ui = 1'($urandom);
            ew = 1'($urandom); mw = 1'($urandom); ctrl = 4'($urandom);
            fa = FWD_REG; va = ba;
            if (rs1 != 0 && ew && erd == rs1) begin fa = FWD_EXMEM; va = eres; end
            else if (rs1 != 0 && mw && mrd == rs1) begin fa = FWD_MEMWB; va = mres; end
            fb = FWD_REG; vb = bb;
            if (rs2 != 0 && ew && erd == rs2) begin fb = FWD_EXMEM; vb = eres; end
            else if (rs2 != 0 && mw && mrd == rs2) begin fb = FWD_MEMWB; vb = mres; end
            @(negedge clk);
            drive_id(v, rs1, rs2, rd, rw, ba, bb, imm, ui, ctrl);
            exp_q.push_back('{a: va, b: ui ? imm : vb, st: vb, ctrl: ctrl, v: v, rw: rw & v,
                              rd: rd, fa: fa, fb: fb});
            @(posedge clk); #1;
            set_fwd(erd, ew, eres, mrd, mw, mres);
            #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (alu_a !== e.a || alu_b !== e.b || ex_store_data !== e.st || alu_ctrl !== e.ctrl ||
                ex_valid !== e.v || ex_reg_write !== e.rw || ex_rd !== e.rd ||
                fwd_a !== e.fa || fwd_b !== e.fb) begin
                n_err++;
                $display("FAIL b2b[%0d]: got a=%h b=%h st=%h c=%h v=%b rw=%b rd=%0d f=%0d/%0d want a=%h b=%h st=%h c=%h v=%b rw=%b rd=%0d f=%0d/%0d",
                         i, alu_a, alu_b, ex_store_data, alu_ctrl, ex_valid, ex_reg_write,
                         ex_rd, fwd_a, fwd_b, e.a, e.b, e.st, e.ctrl, e.v, e.rw, e.rd,
                         e.fa, e.fb);
            end
        end
        set_fwd(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        drive_id(1'b1, 5'd0, 5'd0, 5'd13, 1'b1, 32'h5A5A, 32'hA5A5, 32'h0, 1'b0, ALU_SRA);
        @(posedge clk); #1;
        n_cmp++; if (ex_valid !== 1'b1 || ex_reg_write !== 1'b1) begin n_err++;
            $display("FAIL pre_reset: got v=%b rw=%b want 1 1", ex_valid, ex_reg_write); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || alu_ctrl !== 4'd0 ||
                     ex_rd !== 5'd0) begin n_err++;
            $display("FAIL async_reset: got v=%b rw=%b ctrl=%h rd=%0d want all 0",
                     ex_valid, ex_reg_write, alu_ctrl, ex_rd); end
        n_cmp++; if (alu_a !== 32'd0 || alu_b !== 32'd0) begin n_err++;
            $display("FAIL async_reset_data: got a=%h b=%h want 0 0", alu_a, alu_b); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        drive_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 4'd0);
        set_fwd(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_plain_capture();
        test_double_forward();
        test_immediate();
        test_stall_refresh();
        test_flush_stall();
        test_valid_gating();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register and EX-stage operand forwarding unit; sits directly upstream of the 32-bit ALU.
- Captures decoded operands, immediate, ALU control and destination from decode each cycle.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB, then drives the ALU A/B/ctrl inputs.
- Handles pipeline stall (hold with operand refresh) and flush (bubble insertion).

Parameters:
- DW, 32, datapath width; bit 0 = MSB, matching the ALU's [0:DW-1] ordering.
- RW, 5, register specifier width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold current EX contents
- flush  in  1  replace EX contents with bubble
- id_valid  in  1  decode slot holds a real instruction
- id_rs1, id_rs2  in  RW  source register specifiers
- id_rd  in  RW  destination specifier
- id_reg_write  in  1  instruction writes rd
- id_busA, id_busB  in  DW  register-file read data
- id_imm  in  DW  sign/zero-extended immediate
- id_use_imm  in  1  B operand = immediate
- id_alu_ctrl  in  4  ALU function code, passed through unmodified
- exmem_rd  in  RW  EX/MEM destination
- exmem_reg_write  in  1  EX/MEM writes rd
- exmem_result  in  DW  EX/MEM ALU result
- memwb_rd  in  RW  MEM/WB destination
- memwb_reg_write  in  1  MEM/WB writes rd
- memwb_result  in  DW  MEM/WB writeback data
- alu_a, alu_b  out  DW  forwarded operands to ALU
- alu_ctrl  out  4  registered function code
- ex_store_data  out  DW  forwarded rs2 value, pre-immediate mux
- ex_rd  out  RW  registered destination
- ex_reg_write  out  1  registered write enable, gated by valid
- ex_valid  out  1  EX slot holds a real instruction
- fwd_a, fwd_b  out  2  forward select: 0 = reg, 1 = EX/MEM, 2 = MEM/WB; for debug and verification

Behaviour:
- Reset (rst_n=0, asynchronous): all state registers clear to 0. Resulting outputs:
  - ex_valid=0, ex_reg_write=0, alu_ctrl=0, ex_rd=0.
  - alu_a, alu_b and ex_store_data are 0 unless forwarding matches; rs=0 never forwards, so all are 0 under reset.
- Normal cycle (stall=0, flush=0): on the rising edge, capture all id_* fields.
  - ex_valid <= id_valid.
  - ex_reg_write <= id_reg_write & id_valid.
- Flush: on the edge, ex_valid=0, ex_reg_write=0, ex_rd=0, alu_ctrl=0, rs1/rs2=0. Data fields are don't-care.
- Flush has priority over stall.
- Stall: control fields hold. The stored busA/busB are overwritten with the current forwarded rs1/rs2 values. This means a MEM/WB value that retires while the instruction is held is not lost.
- Forwarding is combinational from registered rs1/rs2 to outputs; there is no extra latency.
  - fwd_a = 1 if exmem_reg_write and exmem_rd == rs1 and rs1 != 0.
  - Otherwise fwd_a = 2 if memwb_reg_write and memwb_rd == rs1 and rs1 != 0.
  - Otherwise fwd_a = 0.
  - fwd_b uses the same rules with rs2.
- EX/MEM has priority over MEM/WB when both match, because it is the younger producer.
- Register 0 is never forwarded; value 0 comes from the stored bus.
- Operand selection:
  - alu_a = forwarded rs1.
  - ex_store_data = forwarded rs2.
  - alu_b = stored imm if use_imm, else forwarded rs2.
- Forwarding is computed regardless of ex_valid. Bubbles carry rs=0, so they never forward.
- Latency: decode to ALU inputs is 1 cycle.
- No arithmetic is performed; widths are passed through unchanged.

Decomposition:
- Shared package pipe_pkg: DW, RW, forward-select encodings FWD_REG=0, FWD_EXMEM=1, FWD_MEMWB=2, and the ALU ctrl codes (ADD=0, SUB=1, ... XOR=15) for bench use.
- One natural sub-module: fwd_select, a combinational comparator plus 3:1 mux per operand, instantiated twice.

Test Plan:
- Reset: rst_n=0 mid-operation with ex_valid=1 -> outputs immediately 0; ex_reg_write=0.
- Plain capture: id_busA=0x00000005, id_busB=0x00000007, ctrl=0, no matches -> next cycle alu_a=5, alu_b=7, fwd_a=fwd_b=0.
- Double forward: rs1=rs2=3, exmem_rd=3 with result 0xAAAA0000, memwb_rd=3 with result 0x5555 -> alu_a=alu_b=0xAAAA0000, fwd=1.
  - Repeat with rs=0 and matching rd=0 -> no forward.
- Immediate: use_imm=1, imm=0xFFFFFFFC, rs2 matches exmem (0x1234) -> alu_b=0xFFFFFFFC, ex_store_data=0x1234.
- Stall refresh: EX holds rs1=4; memwb_rd=4 with result 0xDEADBEEF, stall=1 for 1 cycle; next cycle memwb_reg_write=0 -> alu_a still 0xDEADBEEF, alu_ctrl unchanged.
- Flush vs stall: stall=1 and flush=1 together -> next cycle ex_valid=0, ex_reg_write=0, alu_ctrl=0.
